// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter
//   Merges buffered ALU results and priority load results onto the single
//   register file write port. Per-register write order is preserved, and
//   uncommitted writes are reported so decode can stall on hazards.
// Ports
//   clk, reset             clock; synchronous active-high reset
//   alu_valid/ready/data/reg  ALU result stream (buffered in a FIFO)
//   ld_valid/ready/data/reg   load result stream (priority)
//   write_en/data/reg      registered register file write port
//   query_reg_1/2          decode hazard queries
//   pending_1/2            query register has an uncommitted write
//   fifo_count             ALU FIFO occupancy
module reg_write_arbiter #(
  parameter int unsigned WORD_SIZE    = 32,
  parameter int unsigned ADDR_WIDTH   = 4,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          alu_valid,
  output logic                          alu_ready,
  input  logic [WORD_SIZE-1:0]          alu_data,
  input  logic [ADDR_WIDTH-1:0]         alu_reg,
  input  logic                          ld_valid,
  output logic                          ld_ready,
  input  logic [WORD_SIZE-1:0]          ld_data,
  input  logic [ADDR_WIDTH-1:0]         ld_reg,
  output logic                          write_en,
  output logic [WORD_SIZE-1:0]          write_data,
  output logic [ADDR_WIDTH-1:0]         write_reg,
  input  logic [ADDR_WIDTH-1:0]         query_reg_1,
  input  logic [ADDR_WIDTH-1:0]         query_reg_2,
  output logic                          pending_1,
  output logic                          pending_2,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    SEL_NONE   = 2'd0,
    SEL_LOAD   = 2'd1,
    SEL_POP    = 2'd2,
    SEL_BYPASS = 2'd3
  } sel_t;

  logic [WORD_SIZE-1:0]  mem_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] mem_reg  [FIFO_DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;
  logic [STV_W-1:0]      starve_cnt;

  logic                  full;
  logic                  starve;
  logic                  ld_hit;
  logic                  q1_hit;
  logic                  q2_hit;
  logic                  push;
  logic                  pop;
  sel_t                  sel;
  logic [WORD_SIZE-1:0]  next_data;
  logic [ADDR_WIDTH-1:0] next_reg;

  assign full       = (count == CNT_W'(FIFO_DEPTH));
  assign starve     = (count != '0) && (starve_cnt == STV_W'(STARVE_LIMIT));
  assign alu_ready  = !full;
  assign fifo_count = count;

  // Register matches against valid FIFO slots; a slot is valid when its
  // distance from head (modulo depth) is below the occupancy.
  always_comb begin
    ld_hit = 1'b0;
    q1_hit = 1'b0;
    q2_hit = 1'b0;
    for (int unsigned s = 0; s < FIFO_DEPTH; s++) begin
      if (CNT_W'(PTR_W'(PTR_W'(s) - head)) < count) begin
        if (mem_reg[s] == ld_reg)      ld_hit = 1'b1;
        if (mem_reg[s] == query_reg_1) q1_hit = 1'b1;
        if (mem_reg[s] == query_reg_2) q2_hit = 1'b1;
      end
    end
  end

  assign pending_1 = q1_hit || (write_en && (write_reg == query_reg_1));
  assign pending_2 = q2_hit || (write_en && (write_reg == query_reg_2));

  // Per-cycle source selection in priority order.
  always_comb begin
    sel       = SEL_NONE;
    ld_ready  = !starve && !ld_hit;
    next_data = '0;
    next_reg  = '0;
    if (starve) begin
      sel = SEL_POP;
    end else if (ld_valid && ld_ready) begin
      sel = SEL_LOAD;
    end else if (count != '0) begin
      sel = SEL_POP;
    end else if (alu_valid) begin
      sel = SEL_BYPASS;
    end
    case (sel)
      SEL_LOAD: begin
        next_data = ld_data;
        next_reg  = ld_reg;
      end
      SEL_POP: begin
        next_data = mem_data[head];
        next_reg  = mem_reg[head];
      end
      SEL_BYPASS: begin
        next_data = alu_data;
        next_reg  = alu_reg;
      end
      default: begin
        next_data = '0;
        next_reg  = '0;
      end
    endcase
  end

  // A bypassed ALU result is accepted without being stored.
  assign push = alu_valid && !full && (sel != SEL_BYPASS);
  assign pop  = (sel == SEL_POP);

  // FIFO storage needs no reset; validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[tail] <= alu_data;
      mem_reg[tail]  <= alu_reg;
    end
  end

  // Pointers, occupancy, starvation counter and the write port register.
  always_ff @(posedge clk) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      starve_cnt <= '0;
      write_en   <= 1'b0;
      write_data <= '0;
      write_reg  <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (pop || (count == '0)) begin
        starve_cnt <= '0;
      end else if (sel == SEL_LOAD) begin
        starve_cnt <= starve_cnt + STV_W'(1);
      end
      write_en   <= (sel != SEL_NONE);
      write_data <= next_data;
      write_reg  <= next_reg;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter
//   Directed bench for reg_write_arbiter: a queue-based reference model is
//   checked against the DUT every cycle, and literal expectations pin the
//   key scenarios.
module tb_reg_write_arbiter;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LIMIT = 3;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic        alu_ready;
  logic [31:0] alu_data;
  logic [3:0]  alu_reg;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_data;
  logic [3:0]  ld_reg;
  logic        write_en;
  logic [31:0] write_data;
  logic [3:0]  write_reg;
  logic [3:0]  query_reg_1;
  logic [3:0]  query_reg_2;
  logic        pending_1;
  logic        pending_2;
  logic [2:0]  fifo_count;

  reg_write_arbiter #(
    .WORD_SIZE(32), .ADDR_WIDTH(4), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_data(alu_data), .alu_reg(alu_reg),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_reg(ld_reg),
    .write_en(write_en), .write_data(write_data), .write_reg(write_reg),
    .query_reg_1(query_reg_1), .query_reg_2(query_reg_2),
    .pending_1(pending_1), .pending_2(pending_2), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending ALU results as an ordered queue of (reg, data).
  typedef struct packed {
    logic [3:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  int          m_starve;
  bit          m_we;
  logic [3:0]  m_wr;
  logic [31:0] m_wd;
  bit          live = 0;

  function automatic bit in_q(input logic [3:0] r);
    foreach (mq[i]) if (mq[i].r == r) return 1'b1;
    return 1'b0;
  endfunction

  // Check DUT against the model on the falling edge, then advance the model
  // to what the next rising edge must produce.
  always @(negedge clk) begin
    int   cnt;
    bit   is_full;
    bit   starve_now;
    bit   ld_ok;
    int   kind;   // 0 idle, 1 load, 2 fifo pop, 3 bypass
    ent_t w;
    cnt        = mq.size();
    is_full    = (cnt == DEPTH);
    starve_now = (cnt != 0) && (m_starve == LIMIT);
    ld_ok      = !starve_now && !in_q(ld_reg);
    if (live) begin
      chk("m_fifo_count", 32'(fifo_count), 32'(cnt));
      chk("m_write_en", 32'(write_en), 32'(m_we));
      if (m_we) begin
        chk("m_write_reg", 32'(write_reg), 32'(m_wr));
        chk("m_write_data", write_data, m_wd);
      end
      chk("m_alu_ready", 32'(alu_ready), 32'(!is_full));
      if (ld_valid) chk("m_ld_ready", 32'(ld_ready), 32'(ld_ok));
      chk("m_pending_1", 32'(pending_1), 32'(in_q(query_reg_1) || (m_we && m_wr == query_reg_1)));
      chk("m_pending_2", 32'(pending_2), 32'(in_q(query_reg_2) || (m_we && m_wr == query_reg_2)));
    end
    if (reset) begin
      mq.delete();
      m_starve = 0;
      m_we     = 0;
      m_wr     = '0;
      m_wd     = '0;
      live     = 1;
    end else if (live) begin
      kind = 0;
      if (starve_now)             kind = 2;
      else if (ld_valid && ld_ok) kind = 1;
      else if (cnt != 0)          kind = 2;
      else if (alu_valid)         kind = 3;
      w = '0;
      if (kind == 1) w = '{r: ld_reg, d: ld_data};
      if (kind == 2) w = mq.pop_front();
      if (kind == 3) w = '{r: alu_reg, d: alu_data};
      if (alu_valid && !is_full && kind != 3) mq.push_back('{r: alu_reg, d: alu_data});
      if (kind == 2 || cnt == 0) m_starve = 0;
      else if (kind == 1)        m_starve++;
      m_we = (kind != 0);
      m_wr = w.r;
      m_wd = w.d;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input bit v, input logic [3:0] r, input logic [31:0] d);
    alu_valid = v;
    alu_reg   = r;
    alu_data  = d;
  endtask

  task automatic set_ld(input bit v, input logic [3:0] r, input logic [31:0] d);
    ld_valid = v;
    ld_reg   = r;
    ld_data  = d;
  endtask

  initial begin
    reset       = 1'b1;
    query_reg_1 = 4'd0;
    query_reg_2 = 4'd0;
    set_alu(0, 4'd0, 32'h0);
    set_ld(0, 4'd0, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_write_en", 32'(write_en), 32'd0);
    chk("rst_write_data", write_data, 32'd0);
    chk("rst_alu_ready", 32'(alu_ready), 32'd1);

    // 1: bypass into an empty FIFO
    set_alu(1, 4'd3, 32'h11);
    tick();
    set_alu(0, 4'd0, 32'h0);
    chk("t1_write_en", 32'(write_en), 32'd1);
    chk("t1_write_reg", 32'(write_reg), 32'd3);
    chk("t1_write_data", write_data, 32'h11);
    chk("t1_fifo_count", 32'(fifo_count), 32'd0);
    tick();
    chk("t1_write_en_off", 32'(write_en), 32'd0);

    // 2/4: fill FIFO while loads to r9 win, then the starvation pop
    set_ld(1, 4'd9, 32'h99);
    set_alu(1, 4'd1, 32'hA1); tick();
    chk("t2_count1", 32'(fifo_count), 32'd1);
    chk("t2_load_wr", 32'(write_reg), 32'd9);
    set_alu(1, 4'd2, 32'hA2); tick();
    set_alu(1, 4'd3, 32'hA3); tick();
    set_alu(1, 4'd4, 32'hA4); tick();
    chk("t2_count4", 32'(fifo_count), 32'd4);
    chk("t2_full_ready", 32'(alu_ready), 32'd0);
    chk("t2_load_last", 32'(write_reg), 32'd9);
    set_alu(1, 4'd6, 32'hA6); tick();
    chk("t4_starve_reg", 32'(write_reg), 32'd1);
    chk("t4_starve_data", write_data, 32'hA1);
    chk("t4_count3", 32'(fifo_count), 32'd3);
    set_alu(0, 4'd0, 32'h0);
    set_ld(0, 4'd0, 32'h0);
    tick(); tick(); tick();
    chk("t2_drain_reg", 32'(write_reg), 32'd4);
    chk("t2_drain_data", write_data, 32'hA4);
    chk("t2_drain_count", 32'(fifo_count), 32'd0);
    tick();

    // 3: load to a register still buffered in the FIFO must wait
    set_alu(1, 4'd5, 32'h55);
    set_ld(1, 4'd8, 32'h88);
    tick();
    set_alu(0, 4'd0, 32'h0);
    set_ld(1, 4'd5, 32'h77);
    #1;
    chk("t3_ld_blocked", 32'(ld_ready), 32'd0);
    tick();
    chk("t3_alu_first_reg", 32'(write_reg), 32'd5);
    chk("t3_alu_first_data", write_data, 32'h55);
    chk("t3_ld_unblocked", 32'(ld_ready), 32'd1);
    tick();
    chk("t3_load_data", write_data, 32'h77);
    set_ld(0, 4'd0, 32'h0);
    tick();

    // 5: hazard query on a FIFO tail entry
    query_reg_1 = 4'd7;
    query_reg_2 = 4'd1;
    set_ld(1, 4'd8, 32'h88);
    set_alu(1, 4'd1, 32'h01); tick();
    chk("t5_pend_before", 32'(pending_1), 32'd0);
    set_alu(1, 4'd7, 32'h07); tick();
    chk("t5_pend_tail", 32'(pending_1), 32'd1);
    set_alu(0, 4'd0, 32'h0);
    set_ld(0, 4'd0, 32'h0);
    tick();
    chk("t5_pend_mid", 32'(pending_1), 32'd1);
    tick();
    chk("t5_pend_write", 32'(pending_1), 32'd1);
    chk("t5_write_r7", 32'(write_reg), 32'd7);
    tick();
    chk("t5_pend_clear", 32'(pending_1), 32'd0);

    // 6: reset mid-operation discards buffered results
    set_ld(1, 4'd8, 32'h88);
    set_alu(1, 4'd1, 32'hB1); tick();
    set_alu(1, 4'd2, 32'hB2); tick();
    set_alu(1, 4'd3, 32'hB3); tick();
    chk("t6_count3", 32'(fifo_count), 32'd3);
    chk("t6_we", 32'(write_en), 32'd1);
    set_alu(0, 4'd0, 32'h0);
    set_ld(0, 4'd0, 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_count0", 32'(fifo_count), 32'd0);
    chk("t6_we0", 32'(write_en), 32'd0);
    chk("t6_ready", 32'(alu_ready), 32'd1);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
